icache_refill_axi: RTL and testbench

- AXI4 read-burst refill engine directly downstream of the instruction cache miss path.
- On a miss, the cache hands over the missing address. This block issues one 8-beat AXI read burst and collects the beats into a line buffer.
- It then presents the full 256-bit line to the cache for writing into the selected way's data banks and TAG/V RAM.
- One outstanding request at a time; no write channels.

---
 rtl/icache_refill_axi.sv | 160 ++++++++++++++++
 tb/tb_icache_refill_axi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_axi.sv
// AXI4 read-burst refill engine: one 8-beat burst per I-cache miss, delivered as a 256-bit line.
// Define ICACHE_CRITICAL_WORD_FIRST_EN for a WRAP burst starting at the missing word plus an early critical-word pulse.
module icache_refill_axi #(
  parameter int              LINE_WORDS = 8,
  parameter int              ID_W       = 4,
  parameter logic [ID_W-1:0] AXI_ID     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  output logic                    line_valid,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                    line_err,
  output logic                    crit_valid,
  output logic [31:0]             crit_data,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int CW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               araddr_q, araddr_d;
  logic [CW-1:0]             slot_q, slot_d;
  logic [CW-1:0]             nbeat_q, nbeat_d;
  logic                      err_q, err_d;
  logic [32*LINE_WORDS-1:0]  line_data_q, line_data_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      line_valid_q, line_valid_d;
  logic                      line_err_q, line_err_d;
  logic                      crit_valid_q, crit_valid_d;
  logic [31:0]               crit_data_q, crit_data_d;
  logic                      last_beat;
  logic                      unused_sig;

  assign unused_sig = ^{rid, req_addr[4:0]};

  assign req_ready  = (state_q == S_IDLE);
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign line_valid = line_valid_q;
  assign line_err   = line_err_q;
  assign line_data  = line_data_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign araddr     = araddr_q;
  assign arid       = AXI_ID;
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'b010;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign arburst    = 2'b10;
`else
  assign arburst    = 2'b01;
`endif

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    slot_d       = slot_q;
    nbeat_d      = nbeat_q;
    err_d        = err_q;
    line_data_d  = line_data_q;
    line_valid_d = 1'b0;
    line_err_d   = 1'b0;
    crit_valid_d = 1'b0;
    crit_data_d  = '0;
    last_beat    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          araddr_d = {req_addr[31:2], 2'b00};
          slot_d   = req_addr[4:2];
`else
          araddr_d = {req_addr[31:5], 5'b0};
          slot_d   = '0;
`endif
          nbeat_d  = '0;
          err_d    = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (rvalid && rready_q) begin
          // Exit is decided by beats counted, not by slot index, so a wrapped burst still sees all 8.
          last_beat = (nbeat_q == CW'(LINE_WORDS - 1));
          line_data_d[32*slot_q +: 32] = rdata;
          slot_d  = slot_q + 1'b1;
          nbeat_d = nbeat_q + 1'b1;
          if (rresp != 2'b00 || rlast != last_beat) err_d = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          if (nbeat_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = rdata;
          end
`endif
          if (rlast || last_beat) begin
            state_d      = S_DONE;
            line_valid_d = 1'b1;
            line_err_d   = err_d;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    arvalid_d = (state_d == S_ADDR);
    rready_d  = (state_d == S_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      slot_q       <= '0;
      nbeat_q      <= '0;
      err_q        <= 1'b0;
      line_data_q  <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      line_valid_q <= 1'b0;
      line_err_q   <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      slot_q       <= slot_d;
      nbeat_q      <= nbeat_d;
      err_q        <= err_d;
      line_data_q  <= line_data_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      line_valid_q <= line_valid_d;
      line_err_q   <= line_err_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_axi.sv
// Directed + randomized bench for icache_refill_axi with a line-level reference model and scripted AXI slave.
module tb_icache_refill_axi;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         line_valid;
  logic [255:0] line_data;
  logic         line_err;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] exp_line [8];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  icache_refill_axi dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .line_valid(line_valid), .line_data(line_data), .line_err(line_err),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] model_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = exp_line[i];
    return v;
  endfunction

  // One refill as seen by the cache and a scripted slave.
  // nb: beats delivered; give_last: rlast on final beat; err_at: beat with SLVERR; abort_at: beat where reset hits.
  task automatic txn(input logic [31:0] addr, input int ar_dly, input int gap_at, input int gap_len,
                     input int err_at, input int nb, input bit give_last, input int abort_at, input bit ramp);
    int start, t0, gaps, k;
    bit exp_err;
    logic [31:0] d [8];
    logic [31:0] exp_araddr;
    start      = CWF ? int'(addr[4:2]) : 0;
    exp_araddr = CWF ? {addr[31:2], 2'b00} : {addr[31:5], 5'b0};
    for (int i = 0; i < 8; i++) d[i] = ramp ? 32'hA0 + 32'(i) : $urandom;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    t0 = cyc;
    // A second request during the burst must be ignored.
    req_valid = (ar_dly > 0);
    req_addr  = ~addr;
    chk("arvalid", arvalid, 1'b1);
    chk("araddr", araddr, exp_araddr);
    chk("arlen", arlen, 8'd7);
    chk("arsize", arsize, 3'd2);
    chk("arburst", arburst, CWF ? 2'b10 : 2'b01);
    chk("arid", arid, 4'd0);
    chk("req_ready_busy", req_ready, 1'b0);
    for (int i = 0; i < ar_dly; i++) begin
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = $urandom;
      rlast   = 1'b1;
      step();
      chk("arvalid_hold", arvalid, 1'b1);
      chk("araddr_stable", araddr, exp_araddr);
      chk("rready_in_addr", rready, 1'b0);
    end
    req_valid = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    arready   = 1'b1;
    step();
    arready = 1'b0;
    chk("arvalid_after_hs", arvalid, 1'b0);
    chk("rready_data", rready, 1'b1);
    gaps = 0;
    for (int n = 0; n < nb; n++) begin
      if (n == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          rvalid = 1'b0;
          step();
          gaps++;
          chk("rready_gap", rready, 1'b1);
        end
      end
      rvalid = 1'b1;
      rdata  = d[n];
      rresp  = (n == err_at) ? 2'b10 : 2'b00;
      rlast  = give_last && (n == nb - 1);
      if (n == abort_at) begin
        rst = 1'b0;
        step();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_line_valid", line_valid, 1'b0);
        chk("rst_line_err", line_err, 1'b0);
        chk("rst_crit_valid", crit_valid, 1'b0);
        chk("rst_line_data", line_data, 256'd0);
        for (int i = 0; i < 8; i++) exp_line[i] = '0;
        rst = 1'b1;
        return;
      end
      step();
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      exp_line[(start + n) % 8] = d[n];
      chk("crit_valid", crit_valid, CWF && n == 0);
      if (CWF && n == 0) chk("crit_data", crit_data, d[0]);
    end
    exp_err = (err_at >= 0 && err_at < nb) || (nb != 8) || !give_last;
    chk("line_valid", line_valid, 1'b1);
    chk("line_err", line_err, exp_err);
    chk("line_data", line_data, model_line());
    chk("rready_done", rready, 1'b0);
    chk("req_ready_done", req_ready, 1'b0);
    chk("latency", 256'(cyc - t0 + 1), 256'(2 + ar_dly + gaps + nb));
    step();
    chk("line_valid_pulse", line_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    chk("line_data_hold", line_data, model_line());
    $display("txn addr=%08h ar_dly=%0d gaps=%0d beats=%0d err=%0b", addr, ar_dly, gaps, nb, exp_err);
  endtask

  initial begin
    int mode, nb, err_at;
    bit gl;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < 8; i++) exp_line[i] = '0;
    repeat (3) step();
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_rready", rready, 1'b0);
    chk("reset_line_valid", line_valid, 1'b0);
    chk("reset_line_err", line_err, 1'b0);
    chk("reset_crit_valid", crit_valid, 1'b0);
    chk("reset_line_data", line_data, 256'd0);
    rst = 1'b1;
    step();
    chk("reset_req_ready", req_ready, 1'b1);

    txn(32'h0000_1234, 0, -1, 0, -1, 8, 1'b1, -1, 1'b1);
    txn(32'h0000_1234, 3, 4, 2, -1, 8, 1'b1, -1, 1'b1);
    txn(32'h0000_4568, 0, -1, 0, 5, 8, 1'b1, -1, 1'b0);
    txn(32'h0000_8000, 0, -1, 0, -1, 6, 1'b1, -1, 1'b0);
    txn(32'h0000_9004, 1, -1, 0, -1, 8, 1'b0, -1, 1'b0);
    txn(32'h0000_3000, 0, -1, 0, -1, 8, 1'b1, 3, 1'b0);
    txn(32'h0000_2000, 0, -1, 0, -1, 8, 1'b1, -1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      mode   = $urandom_range(0, 3);
      nb     = (mode == 2) ? $urandom_range(1, 7) : 8;
      gl     = (mode != 3);
      err_at = $urandom_range(0, 15);
      if (err_at > 7) err_at = -1;
      txn($urandom, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
          err_at, nb, gl, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
